// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_e : request-tracking FSM states (FS_IDLE/FS_WAIT/FS_KILL)
//   fetch_entry_t : {insn, pc} payload held by the skid buffer
//   NOP_INSN      : bubble word (ADDI x0,x0,0)
//   TRUE/FALSE    : single-bit truth constants
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,  // no request outstanding
    FS_WAIT = 2'd1,  // one request outstanding, response kept
    FS_KILL = 2'd2   // one request outstanding, response dropped
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] insn;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Clear the byte-offset bits of a fetch address.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched {insn, pc} while the decoder stalls.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   load         : capture load_entry and mark valid
//   drain        : entry consumed, mark empty (ignored when load is also set)
//   clear        : discard the entry (highest priority after reset)
//   load_entry   : payload to capture
//   valid, entry : buffer state
module fetch_skid_buf
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         drain,
  input  logic         clear,
  input  fetch_entry_t load_entry,
  output logic         valid,
  output fetch_entry_t entry
);

  // Load wins over drain so a simultaneous drain+refill keeps the buffer full.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= FALSE;
      entry <= '0;
    end else if (clear) begin
      valid <= FALSE;
    end else if (load) begin
      valid <= TRUE;
      entry <= load_entry;
    end else if (drain) begin
      valid <= FALSE;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage feeding the decoder. Issues single-outstanding
// requests to instruction memory, registers the returned word into ir/pc1,
// absorbs decoder stalls with a one-entry skid buffer, and handles redirects
// by killing the in-flight fetch and inserting NOP bubbles.
// Optional feature macro: FETCH_ALIGN_CHK_EN (misaligned redirect -> fetch_fault).
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   stall                  : hold IF/ID outputs
//   redirect, redirect_pc  : control-flow change and its target
//   imem_req, imem_addr    : request pulse and address (combinational)
//   imem_rvalid, imem_rdata: memory response
//   ir, pc1, if_valid      : registered IF/ID outputs
//   fetch_fault            : sticky misaligned-redirect flag
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] ir,
  output logic [XLEN-1:0] pc1,
  output logic            if_valid,
  output logic            fetch_fault
);

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] fpc, fpc_nxt;
  logic [XLEN-1:0] req_pc, req_pc_nxt;
  logic [XLEN-1:0] ir_nxt, pc1_nxt;
  logic            if_valid_nxt;
  logic            fault_q, fault_nxt;
  logic [XLEN-1:0] tgt;
  logic            misaligned;
  logic            resp;
  logic            issue;
  logic [XLEN-1:0] issue_addr;
  logic            sb_valid, sb_valid_end;
  logic            sb_load, sb_drain, sb_clear;
  fetch_entry_t    sb_entry, sb_load_entry;

  assign tgt = word_align(redirect_pc);

`ifdef FETCH_ALIGN_CHK_EN
  assign misaligned = (redirect_pc[1:0] != 2'b00);
`else
  // Low target bits are simply dropped when alignment checking is off.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign misaligned          = FALSE;
`endif

  // A response only counts while a request is actually outstanding.
  assign resp          = (state != FS_IDLE) && imem_rvalid;
  assign sb_load_entry = '{insn: imem_rdata, pc: req_pc};

  fetch_skid_buf u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (sb_load),
    .drain      (sb_drain),
    .clear      (sb_clear),
    .load_entry (sb_load_entry),
    .valid      (sb_valid),
    .entry      (sb_entry)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= FS_IDLE;
    else     state <= state_nxt;
  end

  // Next-state, request issue and IF/ID datapath selection.
  always_comb begin
    state_nxt    = state;
    fpc_nxt      = fpc;
    req_pc_nxt   = req_pc;
    ir_nxt       = ir;
    pc1_nxt      = pc1;
    if_valid_nxt = if_valid;
    fault_nxt    = fault_q;
    sb_load      = FALSE;
    sb_drain     = FALSE;
    sb_clear     = FALSE;
    sb_valid_end = sb_valid;
    issue        = FALSE;
    issue_addr   = fpc;

    if (redirect) begin
      ir_nxt       = NOP_INSN;
      if_valid_nxt = FALSE;
      sb_clear     = TRUE;
      fpc_nxt      = tgt;
      if (misaligned) begin
        // Park without fetching until a valid redirect arrives.
        state_nxt = FS_IDLE;
        fault_nxt = TRUE;
      end else begin
        fault_nxt = FALSE;
        if ((state == FS_IDLE) || resp) begin
          issue      = TRUE;
          issue_addr = tgt;
        end else begin
          state_nxt = FS_KILL;
        end
      end
    end else begin
      if (stall) begin
        if (resp && (state == FS_WAIT)) begin
          sb_load      = TRUE;
          sb_valid_end = TRUE;
        end
      end else if (sb_valid) begin
        ir_nxt       = sb_entry.insn;
        pc1_nxt      = sb_entry.pc;
        if_valid_nxt = TRUE;
        if (resp && (state == FS_WAIT)) begin
          sb_load = TRUE;
        end else begin
          sb_drain     = TRUE;
          sb_valid_end = FALSE;
        end
      end else if (resp && (state == FS_WAIT)) begin
        ir_nxt       = imem_rdata;
        pc1_nxt      = req_pc;
        if_valid_nxt = TRUE;
      end else begin
        ir_nxt       = NOP_INSN;
        if_valid_nxt = FALSE;
      end

      // Only fetch when the buffer will be empty so nothing can be lost.
      if ((state == FS_IDLE) || resp) begin
        if (!sb_valid_end && !fault_q) begin
          issue      = TRUE;
          issue_addr = fpc;
        end else begin
          state_nxt = FS_IDLE;
        end
      end
    end

    if (issue) begin
      state_nxt  = FS_WAIT;
      req_pc_nxt = issue_addr;
      fpc_nxt    = issue_addr + XLEN'(4);
    end
  end

  assign imem_req  = issue && !rst;
  assign imem_addr = rst ? RESET_PC : issue_addr;

  // IF/ID and fetch-address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc      <= RESET_PC;
      req_pc   <= RESET_PC;
      ir       <= NOP_INSN;
      pc1      <= RESET_PC;
      if_valid <= FALSE;
      fault_q  <= FALSE;
    end else begin
      fpc      <= fpc_nxt;
      req_pc   <= req_pc_nxt;
      ir       <= ir_nxt;
      pc1      <= pc1_nxt;
      if_valid <= if_valid_nxt;
      fault_q  <= fault_nxt;
    end
  end

  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// stall/redirect/latency traffic against a transaction-level reference.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall, redirect, imem_rvalid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, if_valid, fetch_fault;
  logic [31:0] imem_addr, ir, pc1;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .ir          (ir),
    .pc1         (pc1),
    .if_valid    (if_valid),
    .fetch_fault (fetch_fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Memory model state
  logic        mem_busy = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = 32'h0;
  int          lat_min  = 1;
  int          lat_max  = 1;

  // Reference state: next request address, next delivered pc, held outputs
  logic [31:0] exp_req = RST_PC;
  logic [31:0] exp_pc  = RST_PC;
  logic        exp_fault = 1'b0;
  logic [31:0] prev_ir = NOP_INSN;
  logic [31:0] prev_pc1 = RST_PC;
  logic        prev_valid = 1'b0;
  logic        last_req = 1'b0;
  logic [31:0] last_addr = 32'h0;
  int          delivered = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0010_0093;
    if (a == 32'h4) return 32'h0020_0113;
    return {a[31:2], 2'b11} ^ 32'h5A00_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: present memory response, check the request, advance, check outputs.
  task automatic cycle();
    logic        resp_c, stall_c, redir_c, rst_c, bad;
    logic [31:0] tgt;
    rst_c   = rst;
    stall_c = stall;
    redir_c = redirect;
    tgt     = {redirect_pc[31:2], 2'b00};
`ifdef FETCH_ALIGN_CHK_EN
    bad = redir_c && (redirect_pc[1:0] != 2'b00);
`else
    bad = 1'b0;
`endif
    resp_c      = mem_busy && (mem_cnt == 0);
    imem_rvalid = resp_c;
    imem_rdata  = resp_c ? mem_word(mem_addr) : $urandom();

    @(negedge clk);
    last_req  = imem_req;
    last_addr = imem_addr;
    if (rst_c) begin
      check("rst_req", imem_req, 0);
      check("rst_addr", imem_addr, RST_PC);
    end else if (bad) begin
      check("fault_noreq", imem_req, 0);
    end else if (imem_req) begin
      check("one_outstanding", !mem_busy || resp_c, 1);
      check("req_addr", imem_addr, redir_c ? tgt : exp_req);
      exp_req = (redir_c ? tgt : exp_req) + 32'd4;
    end else if (redir_c) begin
      exp_req = tgt;
    end

    @(posedge clk);
    if (resp_c) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (imem_req && !rst_c) begin
      mem_busy = 1'b1;
      mem_addr = imem_addr;
      mem_cnt  = $urandom_range(lat_max, lat_min) - 1;
    end
    #1;

    if (rst_c) begin
      check("rst_ir", ir, NOP_INSN);
      check("rst_pc1", pc1, RST_PC);
      check("rst_valid", if_valid, 0);
      exp_req   = RST_PC;
      exp_pc    = RST_PC;
      exp_fault = 1'b0;
    end else if (redir_c) begin
      check("redir_ir", ir, NOP_INSN);
      check("redir_valid", if_valid, 0);
      exp_pc    = tgt;
      exp_fault = bad;
    end else if (stall_c) begin
      check("stall_ir", ir, prev_ir);
      check("stall_pc1", pc1, prev_pc1);
      check("stall_valid", if_valid, prev_valid);
    end else if (if_valid) begin
      check("deliver_pc", pc1, exp_pc);
      check("deliver_ir", ir, mem_word(pc1));
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end
    if (!if_valid) check("bubble_ir", ir, NOP_INSN);
    check("fault", fetch_fault, exp_fault);
    prev_ir    = ir;
    prev_pc1   = pc1;
    prev_valid = if_valid;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!if_valid && n < budget);
    check(tag, if_valid, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_fffc, wrapped;
    logic [31:0] base;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    lat_min = 1; lat_max = 1;
    repeat (3) cycle();

    // Back-to-back fetch with 1-cycle memory
    rst = 1'b0;
    cycle();
    check("tp1_req0", last_req, 1);
    check("tp1_addr0", last_addr, 32'h0);
    cycle();
    check("tp1_addr1", last_addr, 32'h4);
    check("tp1_ir0", ir, 32'h0010_0093);
    check("tp1_pc0", pc1, 32'h0);
    cycle();
    check("tp1_addr2", last_addr, 32'h8);
    check("tp1_ir1", ir, 32'h0020_0113);
    check("tp1_pc1", pc1, 32'h4);
    check("tp1_valid", if_valid, 1);

    // Stall while the 0x8 response arrives
    stall = 1'b1;
    repeat (3) begin
      cycle();
      check("tp2_noreq", last_req, 0);
      check("tp2_hold", ir, 32'h0020_0113);
    end
    lat_min = 3; lat_max = 3;
    stall = 1'b0;
    cycle();
    check("tp2_rel_ir", ir, mem_word(32'h8));
    check("tp2_rel_pc", pc1, 32'h8);
    check("tp2_rel_req", last_req, 1);
    check("tp2_rel_addr", last_addr, 32'hC);

    // Redirect while 0xC is outstanding (latency 3)
    redirect = 1'b1; redirect_pc = 32'h100;
    cycle();
    check("tp3_noreq", last_req, 0);
    redirect = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("tp3_bubble", if_valid, 0);
      if (last_req) break;
    end
    check("tp3_req", last_req, 1);
    check("tp3_addr", last_addr, 32'h100);
    wait_valid("tp3_timeout", 8);
    check("tp3_pc", pc1, 32'h100);

    // Fill the skid buffer, then redirect+stall (idle, then with a response)
    lat_min = 1; lat_max = 1;
    stall = 1'b1;
    repeat (6) cycle();
    check("tp4_drained", mem_busy, 0);
    redirect = 1'b1; redirect_pc = 32'h180;
    cycle();
    check("tp4_req_a", last_req, 1);
    check("tp4_addr_a", last_addr, 32'h180);
    redirect_pc = 32'h200;
    cycle();
    check("tp4_req_b", last_req, 1);
    check("tp4_addr_b", last_addr, 32'h200);
    redirect = 1'b0; stall = 1'b0;
    cycle();
    check("tp4_ir", ir, mem_word(32'h200));
    check("tp4_pc", pc1, 32'h200);

    // Reset mid-WAIT; stale response lands during reset
    lat_min = 3; lat_max = 3;
    repeat (2) cycle();
    for (int i = 0; i < 6 && !last_req; i++) cycle();
    check("tp5_inflight", mem_busy, 1);
    rst = 1'b1;
    repeat (5) cycle();
    rst = 1'b0;
    cycle();
    check("tp5_req", last_req, 1);
    check("tp5_addr", last_addr, RST_PC);
    wait_valid("tp5_timeout", 8);
    check("tp5_ir", ir, 32'h0010_0093);

    // Sequential fetch across the top of the address space
    lat_min = 1; lat_max = 1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    cycle();
    redirect = 1'b0;
    seen_fffc = 1'b0; wrapped = 1'b0;
    for (int i = 0; i < 12 && !wrapped; i++) begin
      cycle();
      if (last_req && seen_fffc) begin
        check("wrap_addr", last_addr, 32'h0);
        wrapped = 1'b1;
      end else if (last_req && last_addr == 32'hFFFF_FFFC) begin
        seen_fffc = 1'b1;
      end
    end
    check("wrap_seen", wrapped, 1);

    // Misaligned redirect
    redirect = 1'b1; redirect_pc = 32'h102;
    cycle();
    redirect = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
    check("mis_noreq", last_req, 0);
    check("mis_fault", fetch_fault, 1);
    repeat (4) begin
      cycle();
      check("mis_park", last_req, 0);
      check("mis_sticky", fetch_fault, 1);
    end
    redirect = 1'b1; redirect_pc = 32'h200;
    cycle();
    redirect = 1'b0;
    check("mis_recover_req", last_req, 1);
    check("mis_recover_fault", fetch_fault, 0);
    wait_valid("mis_timeout", 8);
    check("mis_recover_pc", pc1, 32'h200);
`else
    check("mis_fault0", fetch_fault, 0);
    wait_valid("mis_timeout", 8);
    check("mis_aligned_pc", pc1, 32'h100);
`endif

    // Full throughput with 1-cycle memory
    redirect = 1'b1; redirect_pc = 32'h40;
    cycle();
    redirect = 1'b0;
    repeat (3) cycle();
    for (int i = 0; i < 20; i++) begin
      cycle();
      check("throughput", if_valid, 1);
    end

    // Random traffic
    delivered = 0;
    for (int i = 0; i < 1500; i++) begin
      lat_min = 1; lat_max = 4;
      stall    = ($urandom_range(0, 3) == 0);
      redirect = ($urandom_range(0, 19) == 0);
      base     = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : 32'h0000_1000;
      redirect_pc = base + 32'($urandom_range(0, 15));
`ifdef FETCH_ALIGN_CHK_EN
      redirect_pc[1:0] = 2'b00;
`endif
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        repeat (6) cycle();
        rst = 1'b0;
      end
      cycle();
    end
    stall = 1'b0; redirect = 1'b0;
    check("progress", delivered >= 100, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage directly upstream of the decoder. Generates the fetch PC, issues single-outstanding requests to instruction memory, and registers the returned word and its address into the IF/ID outputs `ir` and `pc1` consumed by the decoder. Handles stalls with a one-entry skid buffer and branch/jump redirects by killing in-flight fetches and inserting NOP bubbles.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `NOP_INSN`, 32'h0000_0013: bubble word (ADDI x0,x0,0) driven on `ir` when no valid instruction is present.

- `clk`  in  1  Clock; all state updates on the rising edge.
- `rst`  in  1  Reset; synchronous, active-high.
- `stall`  in  1  Hold IF/ID outputs; asserted by hazard logic.
- `redirect`  in  1  Control-flow change; same pulse that drives the decoder `flush`.
- `redirect_pc`  in  32  New fetch target, valid with `redirect`.
- `imem_req`  out  1  One-cycle request pulse; memory always accepts it.
- `imem_addr`  out  32  Request address, valid with `imem_req`.
- `imem_rvalid`  in  1  Response strobe, at least 1 cycle after the request.
- `imem_rdata`  in  32  Instruction word, valid with `imem_rvalid`.
- `ir`  out  32  Registered instruction to decoder.
- `pc1`  out  32  Address of `ir`.
- `if_valid`  out  1  `ir` holds a real instruction, not a bubble.
- `fetch_fault`  out  1  Misaligned redirect flag (only with `FETCH_ALIGN_CHK_EN`; tied 0 otherwise).

## Operation
- Internal: `fpc` (next fetch address), skid buffer `{sb_valid, sb_insn, sb_pc}`, outstanding-request address `req_pc`, FSM.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding; its response is kept.
  - KILL: one request outstanding; its response is dropped.
- Issue condition: the state is IDLE, or the state is WAIT/KILL with `imem_rvalid` high. In addition, `sb_valid` must be 0 at the end of the cycle, and the cycle must not be a stalled cycle that buffers a response.
- On issue: `imem_req`=1, `imem_addr`=`fpc`, `req_pc`<=`fpc`, `fpc`<=`fpc`+4 (mod 2^32, wraps at 32'hFFFF_FFFC to 0), next state WAIT.
- If the issue condition holds with no response in hand, the next state is IDLE.
- WAIT with `imem_rvalid`, no stall:
  - If `sb_valid`=1, load the buffer into `ir/pc1`, and `imem_rdata` goes into the buffer.
  - Otherwise `ir`<=`imem_rdata`, `pc1`<=`req_pc`, `if_valid`<=1.
- WAIT with `imem_rvalid` and `stall`: `ir/pc1/if_valid` hold; the response goes into the skid buffer (`sb_valid`<=1).
- Stall release with `sb_valid`=1: the buffer moves into `ir/pc1` and a new request issues in the same cycle.
- No stall and no new data: `ir`<=`NOP_INSN`, `if_valid`<=0, `pc1` holds.
- Redirect has priority over stall and over a response:
  - `ir`<=`NOP_INSN`, `if_valid`<=0, `sb_valid`<=0, `fpc`<=`redirect_pc`.
  - If IDLE, or `imem_rvalid` is high this cycle: drop any response and issue to `redirect_pc` this cycle (`fpc`<=`redirect_pc`+4).
  - If WAIT without `imem_rvalid`: go to KILL with no issue.
- KILL with `imem_rvalid`: drop the data, issue to `fpc`, go to WAIT.
- `rst` has priority over everything, including `redirect`.

## Timing
- Reset values:
  - `ir`=`NOP_INSN`, `pc1`=`RESET_PC`, `if_valid`=0, `imem_req`=0, `imem_addr`=`RESET_PC`, `fetch_fault`=0.
  - `fpc`=`RESET_PC`, `sb_valid`=0, FSM=IDLE.
- First `imem_req` occurs in the first cycle after `rst` deasserts.
- Latency: `imem_rvalid` in cycle N makes the instruction visible on `ir` in cycle N+1.
- Throughput: 1 instruction/cycle when memory answers 1 cycle after the request.
- A redirect in cycle N puts a bubble on `ir` in N+1. With 1-cycle memory, the first target instruction appears in N+2.
- `imem_req` and `imem_addr` are combinational from the FSM state plus `imem_rvalid`/`stall`/`redirect`. There is no combinational path from `imem_rdata` to any output.
- At most one outstanding request ever exists; `imem_rvalid` is ignored in IDLE.

## Configuration
- `FETCH_ALIGN_CHK_EN` defined: a redirect with `redirect_pc[1:0]`≠0 is treated as follows:
  - No request is issued and the FSM parks in IDLE.
  - `fetch_fault`<=1 and is sticky until the next valid redirect or `rst`.
  - `ir` stays `NOP_INSN`.
- Without it: `redirect_pc[1:0]` is ignored (forced to 0 on `imem_addr`) and `fetch_fault` is constant 0.

## Structure
- Shared package `99_define.vh`:
  - FSM state encodings `FS_IDLE`/`FS_WAIT`/`FS_KILL`.
  - `NOP_INSN` constant.
  - The existing `TRUE`/`FALSE` constants.
- One sub-module, `fetch_skid_buf`: a one-entry buffer holding {insn, pc} with load/drain/clear controls.

## Test plan
- Reset release, memory answering after 1 cycle with words 0x00100093, 0x00200113 → requests to 0x0, 0x4, 0x8 in consecutive cycles; `ir`/`pc1` = 0x00100093/0x0, then 0x00200113/0x4, with `if_valid`=1.
- `stall` high for 3 cycles while a response for 0x8 arrives → `ir` holds the 0x4 instruction, the 0x8 word is buffered, and no request is issued. On release, `ir` takes the 0x8 word and a request to 0xC issues the same cycle.
- `redirect` to 0x100 while the 0xC request is outstanding, memory latency 3 → FSM goes to KILL, the 0xC data is dropped, the next request is to 0x100, and `ir`=0x00000013 with `if_valid`=0 until the 0x100 data returns.
- `redirect` and `stall` together, with `imem_rvalid` high → data dropped, skid buffer cleared, request to `redirect_pc` issued the same cycle.
- `rst` asserted mid-WAIT with a later `imem_rvalid` → all outputs return to reset values and the stale response is ignored.
- Sequential fetch across 0xFFFF_FFFC → next `imem_addr` is 0x0. With `FETCH_ALIGN_CHK_EN`, a redirect to 0x102 gives `fetch_fault`=1 and no `imem_req`.
